uart_tx_arb: RTL and testbench
==============================

// Module: uart_tx_arb
// PURPOSE
// - Shares the single UART transmitter (uart_top i_tx_data/i_tx_stb/o_tx_busy) between N_REQ byte sources.
// - Typical sources: the sequencer TX path, an RX echo path and a debug/status dump.
// - Round-robin arbitration with a per-requester valid/ack handshake. Paces strobes on the UART busy
//   protocol; ack timeout recovery. Sits between the requesters and uart_top in the nexys3 top level.
// PARAMETERS
// - N_REQ   2    number of requesters (2..8)
// - DW      8    byte width presented to the UART
// - ACK_TO  64   cycles to wait for i_tx_busy to rise after a strobe before declaring an ack error
// PORTS
// - clk          in   1         100MHz system clock
// - rst_n        in   1         asynchronous, active-low reset
// - i_req_valid  in   N_REQ     requester k holds a byte for transmission
// - i_req_data   in   N_REQ*DW  byte of requester k at [k*DW +: DW]
// - o_req_ack    out  N_REQ     one-cycle pulse: byte of requester k accepted
// - o_grant      out  N_REQ     one-hot current owner; 0 when idle
// - o_tx_data    out  DW        to uart_top i_tx_data
// - o_tx_stb     out  1         to uart_top i_tx_stb; one-cycle pulse
// - i_tx_busy    in   1         from uart_top o_tx_busy
// - o_ack_err    out  1         sticky; set on ack timeout; cleared only by reset
// - o_active     out  1         high in any state other than IDLE
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, state IDLE, rr pointer = 0, timeout counter = 0.
// - FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
// - IDLE
//   - If any i_req_valid is set and i_tx_busy=0: pick the first valid requester at or after the rr pointer
//     (wrapping N_REQ-1 -> 0).
//   - Register its byte into o_tx_data, set o_grant, go to ISSUE.
//   - If i_tx_busy=1, stay in IDLE.
// - ISSUE (1 cycle): o_tx_stb=1 and o_req_ack[g]=1. rr pointer <= g+1 mod N_REQ. Go to WAIT_HI.
// - WAIT_HI
//   - On i_tx_busy=1: go to WAIT_LO.
//   - If no rise within ACK_TO cycles: set o_ack_err, go to IDLE. The byte counts as consumed (no retry).
// - WAIT_LO: on i_tx_busy=0, clear o_grant and go to IDLE.
// - Throughput: minimum 3 cycles of overhead between the byte end and the next strobe (WAIT_LO->IDLE->ISSUE).
// - Data hold: o_tx_data stays stable from ISSUE until the next IDLE grant. The requester may change
//   i_req_data after its ack.
// - Request changes:
//   - A valid that drops while another requester is granted is ignored.
//   - A valid that is still high after its ack is a new byte.
// - Simultaneous requests: exactly one ack per ISSUE. Losers keep valid and are served in rr order.
//   No requester waits more than N_REQ-1 grants.
// - Reset mid-transfer: the FSM returns to IDLE at once and o_tx_stb drops. uart_top has its own reset,
//   and its in-flight byte is not tracked.
// - Timeout counter: log2(ACK_TO)+1 bits, saturating, cleared on entry to WAIT_HI.
// CONFIGURATION
// - Macro: UART_TX_ARB_LOCK_EN.
// - Defined:
//   - Adds input i_req_lock [N_REQ].
//   - If the owner holds lock=1 at WAIT_LO exit, IDLE grants only that requester, which keeps
//     multi-byte packets contiguous.
//   - The rr pointer does not advance while locked.
//   - The lock releases when lock=0 at WAIT_LO exit, or on an ack error.
// - Undefined: no i_req_lock port; pure per-byte round-robin.
// STRUCTURE
// - Shared include uart_arb_definitions.v:
//   - state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT_HI=2'd2, ARB_WAIT_LO=2'd3
//   - default DW and ACK_TO constants
// - Sub-module rr_pick (combinational): inputs req[N_REQ] and ptr; outputs one-hot grant and index.
//   Reused by later arbiters.
// - FSM, timeout counter, data register and lock logic live in uart_tx_arb.
// TESTING
// - Single byte:
//   - Stimulus: req0 valid with 0x41; the busy model rises 2 cycles after stb and holds 20 cycles.
//   - Response: one stb with o_tx_data=0x41 and ack0 in the same cycle. o_grant=01 until busy falls,
//     then o_active=0.
// - Contention:
//   - Stimulus: req0=0x10 and req1=0x20 both held valid from reset.
//   - Response: order 0x10, 0x20, 0x10, 0x20. Each ack coincides with its stb.
// - Busy gate: hold i_tx_busy=1 from reset with req0 valid -> no stb until busy drops; stb follows 2 cycles later.
// - Timeout:
//   - Stimulus: the busy model never rises.
//   - Response: o_ack_err=1 exactly ACK_TO cycles after the WAIT_HI entry. The FSM returns to IDLE and
//     serves the next request.
// - Reset mid-op:
//   - Stimulus: assert rst_n=0 during WAIT_LO.
//   - Response: o_grant=0, o_tx_stb=0 and o_ack_err=0 asynchronously. Arbitration starts at req0 after release.
// - LOCK_EN:
//   - Stimulus: req1 locked for 3 bytes while req0 is valid.
//   - Response: bytes go out as req1 x3, then req0. Without the macro they alternate.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
// The optional UART_TX_ARB_LOCK_EN build macro is handled in the interface and top files.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT_HI = 2'd2,
        ARB_WAIT_LO = 2'd3
    } arb_state_e;

    localparam int DEF_N_REQ  = 2;
    localparam int DEF_DW     = 8;
    localparam int DEF_ACK_TO = 64;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and UART-side bundle for uart_tx_arb.
// The req_lock lane exists only when UART_TX_ARB_LOCK_EN is defined.
interface uart_tx_arb_if
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DW    = DEF_DW
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ack;
    logic [N_REQ-1:0]    grant;
    logic [DW-1:0]       tx_data;
    logic                tx_stb;
    logic                tx_busy;
    logic                ack_err;
    logic                active;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N_REQ-1:0]    req_lock;

    modport master (
        output req_valid, req_data, req_lock, tx_busy,
        input  req_ack, grant, tx_data, tx_stb, ack_err, active
    );
    modport slave (
        input  req_valid, req_data, req_lock, tx_busy,
        output req_ack, grant, tx_data, tx_stb, ack_err, active
    );
`else
    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ack, grant, tx_data, tx_stb, ack_err, active
    );
    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ack, grant, tx_data, tx_stb, ack_err, active
    );
`endif
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Kept generic so other arbiters can reuse it.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= N_REQ) c = c - N_REQ;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin share of one UART transmitter between N_REQ byte sources.
// Define UART_TX_ARB_LOCK_EN to let an owner keep the grant across a multi-byte packet.
//
// state       | meaning
// ARB_IDLE    | no owner; grant the next valid requester when the UART is free
// ARB_ISSUE   | one-cycle strobe to the UART and ack to the owner
// ARB_WAIT_HI | waiting for tx_busy to rise, bounded by ACK_TO
// ARB_WAIT_LO | UART shifting the byte; release grant when tx_busy falls
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DW     = DEF_DW,
    parameter int ACK_TO = DEF_ACK_TO
) (
    input logic          clk,
    input logic          rst_n,
    uart_tx_arb_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(ACK_TO) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TO - 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(ACK_TO);

    arb_state_e       state, state_nx;
    logic [IW-1:0]    ptr, owner, pick_idx, ptr_inc;
    logic [N_REQ-1:0] pick_grant, req_eff, grant_q;
    logic             pick_any, timeout;
    logic [CW-1:0]    to_cnt;
    logic [DW-1:0]    data_q;
    logic             err_q;

`ifdef UART_TX_ARB_LOCK_EN
    logic             lock_q;
    logic [IW-1:0]    lock_idx;
    logic [N_REQ-1:0] lock_mask;

    // While a packet is locked only its owner may win the next grant.
    always_comb begin
        lock_mask           = '0;
        lock_mask[lock_idx] = 1'b1;
        req_eff             = lock_q ? (bus.req_valid & lock_mask) : bus.req_valid;
    end
`else
    assign req_eff = bus.req_valid;
`endif

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req   (req_eff),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign ptr_inc = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign timeout = (state == ARB_WAIT_HI) && !bus.tx_busy && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE:    if (pick_any && !bus.tx_busy) state_nx = ARB_ISSUE;
            ARB_ISSUE:   state_nx = ARB_WAIT_HI;
            ARB_WAIT_HI: begin
                if (bus.tx_busy)  state_nx = ARB_WAIT_LO;
                else if (timeout) state_nx = ARB_IDLE;
            end
            ARB_WAIT_LO: if (!bus.tx_busy) state_nx = ARB_IDLE;
            default:     state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            owner    <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            to_cnt   <= '0;
            err_q    <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q   <= 1'b0;
            lock_idx <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (state_nx == ARB_ISSUE) begin
                        data_q  <= bus.req_data[pick_idx*DW +: DW];
                        grant_q <= pick_grant;
                        owner   <= pick_idx;
                    end
                end
                ARB_ISSUE: begin
                    to_cnt <= '0;
`ifdef UART_TX_ARB_LOCK_EN
                    if (!lock_q) ptr <= ptr_inc;
`else
                    ptr <= ptr_inc;
`endif
                end
                ARB_WAIT_HI: begin
                    // A timed-out byte is dropped; the owner is not retried.
                    if (timeout) begin
                        err_q   <= 1'b1;
                        grant_q <= '0;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_q  <= 1'b0;
`endif
                    end else if (!bus.tx_busy && to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ARB_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        grant_q  <= '0;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_q   <= |(grant_q & bus.req_lock);
                        lock_idx <= owner;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_stb  = (state == ARB_ISSUE);
    assign bus.req_ack = grant_q & {N_REQ{state == ARB_ISSUE}};
    assign bus.grant   = grant_q;
    assign bus.tx_data = data_q;
    assign bus.ack_err = err_q;
    assign bus.active  = (state != ARB_IDLE);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic against a queue model.
// Exercises the lock path when UART_TX_ARB_LOCK_EN is defined, plain alternation otherwise.
module tb_uart_tx_arb;
    localparam int NR  = 3;
    localparam int DW  = 8;
    localparam int ATO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.N_REQ(NR), .DW(DW)) bus();

    uart_tx_arb #(.N_REQ(NR), .DW(DW), .ACK_TO(ATO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, stray = 0, bad_ack = 0;
    logic [7:0]    src_q[NR][$];
    bit            lock_en[NR];
    logic [7:0]    log_d[$];
    logic [NR-1:0] log_g[$];
    int            log_t[$];
    logic [7:0]    exp_q[$];
    bit busy_force = 1'b0, never_rise = 1'b0;
    int rise_dly = 2, hold = 20, pend = 0, hold_left = 0;

    // Environment: strobe log, UART busy model and requesters, all updated on the falling edge.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend          = 0;
                hold_left     = 0;
                bus.req_valid = '0;
            end else begin
                if (bus.tx_stb) begin
                    log_d.push_back(bus.tx_data);
                    log_g.push_back(bus.grant);
                    log_t.push_back(cyc);
                    if (bus.req_ack !== bus.grant || $countones(bus.grant) != 1) bad_ack++;
                end else if (bus.req_ack != '0) begin
                    stray++;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) hold_left = hold;
                end else if (hold_left > 0) begin
                    hold_left--;
                end
                if (bus.tx_stb && !never_rise) pend = rise_dly;
                for (int k = 0; k < NR; k++)
                    if (bus.req_ack[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                for (int k = 0; k < NR; k++) begin
                    bus.req_valid[k]         = (src_q[k].size() > 0);
                    bus.req_data[k*DW +: DW] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
`ifdef UART_TX_ARB_LOCK_EN
                    bus.req_lock[k]          = lock_en[k] && (src_q[k].size() > 0);
`endif
                end
            end
            bus.tx_busy = busy_force || (hold_left > 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_env();
        for (int k = 0; k < NR; k++) begin
            src_q[k].delete();
            lock_en[k] = 1'b0;
        end
        log_d.delete();
        log_g.delete();
        log_t.delete();
        stray   = 0;
        bad_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        clear_env();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                !bus.active && !bus.tx_busy && pend == 0) break;
        end
        n_checks++;
        if (i == budget) begin
            n_fail++;
            $display("FAIL %s_drain: not idle after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic wait_stb(input int n, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (log_d.size() >= n) break;
            tick();
        end
        n_checks++;
        if (log_d.size() < n) begin
            n_fail++;
            $display("FAIL %s_stb: saw %0d strobes, required %0d", name, log_d.size(), n);
        end
    endtask

    task automatic check_log(input string name);
        n_checks++;
        if (log_d.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: %0d bytes sent, required %0d", name, log_d.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_d.size(); i++) begin
            n_checks++;
            if (log_d[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, log_d[i], exp_q[i]);
            end
        end
        n_checks++;
        if (stray !== 0 || bad_ack !== 0) begin
            n_fail++;
            $display("FAIL %s_ack_pairing: stray=%0d bad=%0d, required 0 and 0", name, stray, bad_ack);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({bus.tx_stb, bus.req_ack, bus.grant, bus.tx_data, bus.ack_err, bus.active} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: stb=%b ack=%b grant=%b data=%h err=%b active=%b, required all 0",
                     bus.tx_stb, bus.req_ack, bus.grant, bus.tx_data, bus.ack_err, bus.active);
        end
        do_reset();
        tick();
        n_checks++;
        if (bus.active !== 1'b0 || bus.grant !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: active=%b grant=%b, required 0 and 000", bus.active, bus.grant);
        end
    endtask

    task automatic test_single();
        int i;
        do_reset();
        rise_dly = 2;
        hold     = 20;
        src_q[0].push_back(8'h41);
        wait_stb(1, 20, "single");
        for (i = 0; i < 10 && !bus.tx_busy; i++) tick();
        tick();
        n_checks++;
        if (bus.grant !== 3'b001 || bus.active !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant_busy: grant=%b active=%b, required 001 and 1", bus.grant, bus.active);
        end
        wait_done(100, "single");
        n_checks++;
        if (bus.grant !== '0 || bus.active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: grant=%b active=%b, required 000 and 0", bus.grant, bus.active);
        end
        n_checks++;
        if (log_g.size() > 0 && log_g[0] !== 3'b001) begin
            n_fail++;
            $display("FAIL single_grant_at_stb: got %b, required 001", log_g[0]);
        end
        exp_q = '{8'h41};
        check_log("single");
    endtask

    task automatic test_contention();
        do_reset();
        rise_dly = 2;
        hold     = 6;
        src_q[0] = '{8'h10, 8'h10};
        src_q[1] = '{8'h20, 8'h20};
        wait_done(300, "contention");
        exp_q = '{8'h10, 8'h20, 8'h10, 8'h20};
        check_log("contention");
    endtask

    task automatic test_busy_gate();
        int c_rel;
        busy_force = 1'b1;
        do_reset();
        rise_dly = 2;
        hold     = 4;
        src_q[0].push_back(8'h55);
        repeat (12) tick();
        n_checks++;
        if (log_d.size() != 0) begin
            n_fail++;
            $display("FAIL busy_gate_hold: %0d strobes while busy, required 0", log_d.size());
        end
        busy_force = 1'b0;
        c_rel = cyc + 1;
        wait_stb(1, 10, "busy_gate");
        n_checks++;
        if (log_t.size() > 0 && log_t[0] != c_rel + 1) begin
            n_fail++;
            $display("FAIL busy_gate_latency: stb at cycle %0d, required %0d", log_t[0], c_rel + 1);
        end
        wait_done(100, "busy_gate");
        exp_q = '{8'h55};
        check_log("busy_gate");
    endtask

    task automatic test_timeout();
        int t_s;
        do_reset();
        never_rise = 1'b1;
        src_q[0].push_back(8'hA5);
        src_q[1].push_back(8'h5A);
        wait_stb(1, 20, "timeout");
        t_s = (log_t.size() > 0) ? log_t[0] : cyc;
        for (int i = 0; i < 4 * ATO && !bus.ack_err; i++) tick();
        n_checks++;
        if (cyc - t_s != ATO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: err after %0d cycles from stb, required %0d", cyc - t_s, ATO + 1);
        end
        n_checks++;
        if (bus.ack_err !== 1'b1 || bus.active !== 1'b0 || bus.grant !== '0) begin
            n_fail++;
            $display("FAIL timeout_state: err=%b active=%b grant=%b, required 1, 0, 000",
                     bus.ack_err, bus.active, bus.grant);
        end
        wait_done(200, "timeout");
        exp_q = '{8'hA5, 8'h5A};
        check_log("timeout");
        n_checks++;
        if (bus.ack_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b, required 1", bus.ack_err);
        end
        never_rise = 1'b0;
    endtask

    task automatic test_reset_midop();
        int i;
        clear_env();
        rise_dly = 2;
        hold     = 30;
        src_q[0].push_back(8'h77);
        wait_stb(1, 20, "midop");
        for (i = 0; i < 10 && !bus.tx_busy; i++) tick();
        tick();
        n_checks++;
        if (bus.grant !== 3'b001 || bus.active !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_pre: grant=%b active=%b, required 001 and 1", bus.grant, bus.active);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.grant !== '0 || bus.tx_stb !== 1'b0 || bus.ack_err !== 1'b0 || bus.active !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_async: grant=%b stb=%b err=%b active=%b, required all 0",
                     bus.grant, bus.tx_stb, bus.ack_err, bus.active);
        end
        clear_env();
        repeat (2) tick();
        hold     = 4;
        src_q[0].push_back(8'h01);
        src_q[1].push_back(8'h02);
        rst_n = 1'b1;
        wait_done(200, "midop");
        exp_q = '{8'h01, 8'h02};
        check_log("midop");
    endtask

    task automatic test_random();
        logic [7:0] ref_q[NR][$];
        int p, left, k;
        logic [7:0] b;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            rise_dly = $urandom_range(1, 4);
            hold     = $urandom_range(1, 8);
            left     = 0;
            for (int r = 0; r < NR; r++) begin
                ref_q[r].delete();
                for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                    b = 8'($urandom);
                    src_q[r].push_back(b);
                    ref_q[r].push_back(b);
                    left++;
                end
            end
            // Reference order: first pending source at or after the pointer, pointer moves past the winner.
            exp_q.delete();
            p = 0;
            while (left > 0) begin
                for (int i = 0; i < NR; i++) begin
                    k = (p + i) % NR;
                    if (ref_q[k].size() > 0) begin
                        exp_q.push_back(ref_q[k].pop_front());
                        p = (k + 1) % NR;
                        left--;
                        break;
                    end
                end
            end
            wait_done(2000, "random");
            check_log("random");
        end
    endtask

    task automatic test_lock();
        do_reset();
        rise_dly = 2;
        hold     = 5;
        src_q[1] = '{8'hB1, 8'hB2, 8'hB3};
        lock_en[1] = 1'b1;
        wait_stb(1, 20, "lock");
        src_q[0].push_back(8'hC0);
        wait_done(400, "lock");
`ifdef UART_TX_ARB_LOCK_EN
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
`else
        exp_q = '{8'hB1, 8'hC0, 8'hB2, 8'hB3};
`endif
        check_log("lock");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_busy_gate();
        test_timeout();
        test_reset_midop();
        test_random();
        test_lock();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
